traffic_request_latch: RTL and testbench
========================================

TRAFFIC_REQUEST_LATCH -- requirements
Module: traffic_request_latch

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 20, meaning consecutive clk cycles a synchronized input must hold a new level before it is accepted (legal range 2..255; 20 ms at the 1 kHz system clock).
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  system clock, 1 kHz, rising-edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 raw_request  input  6  unsynchronized button/sensor lines; channel map: [0] straight street straight lane car sensor, [1] straight street turn lane car sensor, [2] cross street straight lane car sensor, [3] cross street turn lane car sensor, [4] straight street pedestrian button, [5] cross street pedestrian button.
REQ-006 serve  input  6  per-channel service indication, driven by the controller's outputs: [3:0] lane green lights, [5:4] walk lights; same channel map as raw_request.
REQ-007 request  output  6  latched, debounced per-channel requests; these are the controller's button/sensor inputs.
REQ-008 pending_any  output  1  OR of request.
REQ-009 pending_count  output  3  number of set request bits, 0..6.
REQ-010 first_valid  output  1  first_index holds a pending channel.
REQ-011 first_index  output  3  earliest-latched pending channel, 0..5.

Function
REQ-012 Each raw_request bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Each channel SHALL have an 8-bit debounce counter and a stable bit; the counter clears on every cycle the synchronized value equals stable, otherwise increments.
REQ-014 The stable bit SHALL take the synchronized value on the edge where the counter reaches DEBOUNCE_CYCLES; the counter clears on that same edge.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change stable.
REQ-016 request[i] SHALL set on the edge after stable[i] rises 0->1, provided serve[i]=0 in that cycle.
REQ-017 A stable rise while serve[i]=1 SHALL be discarded, because the channel is already being served.
REQ-018 request[i] SHALL clear on any edge where serve[i]=1 (level-sensitive); clear has priority over a simultaneous set.
REQ-019 A held input (stable stays 1) SHALL NOT re-latch after clearing; a new 0->1 stable transition is required.
REQ-020 Latency: with raw_request[i] high before edge 1 and serve[i]=0, request[i] SHALL be high after edge DEBOUNCE_CYCLES+3 and not before.
REQ-021 pending_any and pending_count SHALL be combinational functions of registered request.
REQ-022 first_index/first_valid SHALL be registered and behave as follows:
- When no request is pending and one or more bits set in one cycle, the lowest set index is captured.
- While the captured channel stays pending, first_index is held.
- When the captured channel clears, the lowest remaining pending index is captured on that edge.
- If none remain pending, first_valid=0 and first_index=0.
REQ-023 Requests SHALL never wrap or overflow; pending_count saturates naturally at 6.

Reset
REQ-024 rst_n low SHALL asynchronously force all outputs to 0: request=0, pending_any=0, pending_count=0, first_valid=0, first_index=0.
REQ-025 rst_n low SHALL also force all synchronizer flops, stable bits and debounce counters to 0.
REQ-026 Reset asserted mid-debounce or with requests pending SHALL discard all state.
REQ-027 After release, an input still held high SHALL re-qualify with full REQ-020 latency.
REQ-028 Reset release SHALL be synchronized to clk by the integrating top level.

Structure
REQ-029 The channel-index constants (0..5) and the default DEBOUNCE_CYCLES SHALL live in a shared package/include file used by this block and the controller.
REQ-030 The per-channel synchronizer, debounce and stable logic SHALL be a sub-module named input_debouncer, instantiated 6 times.
REQ-031 The latch, first-index and count logic SHALL be in the top module.

Verification
REQ-032 Qualification and latency: DEBOUNCE_CYCLES=20, raw_request[4] high from cycle 0, serve=0 -> request[4] rises after edge 23, pending_count=1, first_index=4.
REQ-033 Glitch rejection: raw_request[2] pulse of 10 cycles -> request stays 0x00 and the counter returns to 0.
REQ-034 Simultaneous arrival and hand-off: raw_request[1] and raw_request[3] rise together -> request=0x0A, first_index=1; then serve[1]=1 -> request=0x08, first_index=3 on the same edge.
REQ-035 Clear priority and discard:
- Stable rise of channel 0 coinciding with serve[0]=1 -> request[0] stays 0.
- Input held high after serve drops -> request[0] stays 0 until a 0->1 re-qualification.
REQ-036 Reset mid-operation: request=0x3F and rst_n pulsed low for 3 cycles -> all outputs are 0 immediately; inputs still high -> request returns 0x3F 23 edges after release.

Source files
------------

// File: rtl/traffic_request_latch_pkg.sv
// Shared channel map, debounce default and small vector helpers for the
// traffic request latch and the signal controller that consumes it.
package traffic_request_latch_pkg;

    localparam int unsigned NUM_CH                  = 6;
    localparam int unsigned CH_IDX_W                = 3;
    localparam int unsigned CNT_W                   = 8;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 20;

    localparam int unsigned CH_STRAIGHT_CAR  = 0;
    localparam int unsigned CH_STRAIGHT_TURN = 1;
    localparam int unsigned CH_CROSS_CAR     = 2;
    localparam int unsigned CH_CROSS_TURN    = 3;
    localparam int unsigned CH_STRAIGHT_PED  = 4;
    localparam int unsigned CH_CROSS_PED     = 5;

    typedef logic [NUM_CH-1:0] ch_vec_t;

    // Lowest set bit position; 0 when the vector is empty.
    function automatic logic [CH_IDX_W-1:0] lowest_index(input ch_vec_t v);
        logic [CH_IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (v[i]) idx = CH_IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [CH_IDX_W-1:0] count_ones(input ch_vec_t v);
        logic [CH_IDX_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            n = n + CH_IDX_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/traffic_request_latch_input_debouncer.sv
// One channel: 2-flop synchronizer, saturating-free debounce counter and a
// stable level; emits a one-cycle pulse on the edge stable goes 0->1.
module input_debouncer
    import traffic_request_latch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rose
);

    logic [1:0]       sync;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // Counter restarts whenever the synchronized level agrees with stable,
    // so only an uninterrupted run of DEBOUNCE_CYCLES flips stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '0;
            stable <= 1'b0;
            cnt    <= '0;
            rose   <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            rose <= 1'b0;
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt    <= '0;
                stable <= sync[1];
                rose   <= sync[1];
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/traffic_request_latch.sv
// Debounced, latched per-channel traffic requests with pending summary and
// a sticky "first pending channel" pointer for the signal controller.
module traffic_request_latch
    import traffic_request_latch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   raw_request,
    input  logic [NUM_CH-1:0]   serve,
    output logic [NUM_CH-1:0]   request,
    output logic                pending_any,
    output logic [CH_IDX_W-1:0] pending_count,
    output logic                first_valid,
    output logic [CH_IDX_W-1:0] first_index
);

    ch_vec_t rose;
    ch_vec_t request_nxt;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        input_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (raw_request[g]),
            .rose (rose[g])
        );
    end

    // Serve clears level-sensitively and wins over a same-cycle rise.
    always_comb begin
        request_nxt   = (request | rose) & ~serve;
        pending_any   = |request;
        pending_count = count_ones(request);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            request     <= '0;
            first_valid <= 1'b0;
            first_index <= '0;
        end else begin
            request <= request_nxt;
            if (!first_valid || !request_nxt[first_index]) begin
                first_valid <= |request_nxt;
                first_index <= lowest_index(request_nxt);
            end
        end
    end

endmodule

// File: tb/tb_traffic_request_latch.sv
// Scenario bench for traffic_request_latch: expected output words are queued
// as stimulus is applied and compared when the DUT is sampled.
module tb_traffic_request_latch;
    import traffic_request_latch_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [5:0] raw_request;
    logic [5:0] serve;
    logic [5:0] request;
    logic       pending_any;
    logic [2:0] pending_count;
    logic       first_valid;
    logic [2:0] first_index;

    logic [13:0] exp_q[$];
    int vectors;
    int miscompares;

    traffic_request_latch #(.DEBOUNCE_CYCLES(20)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .raw_request  (raw_request),
        .serve        (serve),
        .request      (request),
        .pending_any  (pending_any),
        .pending_count(pending_count),
        .first_valid  (first_valid),
        .first_index  (first_index)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [13:0] obs();
        return {request, pending_any, pending_count, first_valid, first_index};
    endfunction

    // Independent model of the summary outputs for an expected request vector.
    function automatic logic [13:0] model(input logic [5:0] req, input logic fv,
                                          input logic [2:0] fi);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 6; i++) if (req[i]) n = n + 3'd1;
        return {req, |req, n, fv, fi};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [13:0] e;
        rst_n = 1'b0;
        raw_request = '0;
        serve = '0;
        exp_q.push_back(model(6'h00, 1'b0, 3'd0));
        step(2);
        e = exp_q.pop_front(); vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL reset_outputs: got %h want %h", obs(), e); end
        rst_n = 1'b1;
    endtask

    task automatic test_qualify();
        logic [13:0] e;
        raw_request[4] = 1'b1;
        exp_q.push_back(model(6'h00, 1'b0, 3'd0));
        step(22);
        e = exp_q.pop_front(); vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL qual_edge22: got %h want %h", obs(), e); end
        exp_q.push_back(model(6'h10, 1'b1, 3'd4));
        step(1);
        e = exp_q.pop_front(); vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL qual_edge23: got %h want %h", obs(), e); end
        serve = 6'h10;
        raw_request = '0;
        exp_q.push_back(model(6'h00, 1'b0, 3'd0));
        step(1);
        e = exp_q.pop_front(); vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL qual_serve_clear: got %h want %h", obs(), e); end
        step(25);
        serve = '0;
        exp_q.push_back(model(6'h00, 1'b0, 3'd0));
        step(2);
        e = exp_q.pop_front(); vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL qual_after_fall: got %h want %h", obs(), e); end
    endtask

    task automatic test_glitch();
        logic [13:0] e;
        int lens[2] = '{10, 19};
        foreach (lens[k]) begin
            raw_request[2] = 1'b1;
            step(lens[k]);
            raw_request[2] = 1'b0;
            exp_q.push_back(model(6'h00, 1'b0, 3'd0));
            step(30);
            e = exp_q.pop_front(); vectors++;
            if (obs() !== e) begin miscompares++; $display("FAIL glitch_%0d: got %h want %h", lens[k], obs(), e); end
            vectors++;
            if (u_dut.g_ch[2].u_deb.cnt !== 8'd0) begin
                miscompares++;
                $display("FAIL glitch_%0d_counter: got %0d want 0", lens[k], u_dut.g_ch[2].u_deb.cnt);
            end
        end
        // A pulse of exactly the debounce length qualifies.
        raw_request[2] = 1'b1;
        step(20);
        raw_request[2] = 1'b0;
        exp_q.push_back(model(6'h00, 1'b0, 3'd0));
        step(2);
        e = exp_q.pop_front(); vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL pulse20_edge22: got %h want %h", obs(), e); end
        exp_q.push_back(model(6'h04, 1'b1, 3'd2));
        step(1);
        e = exp_q.pop_front(); vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL pulse20_edge23: got %h want %h", obs(), e); end
        serve = 6'h04;
        step(1);
        serve = '0;
        step(25);
    endtask

    task automatic test_simultaneous();
        logic [13:0] e;
        raw_request = 6'h0A;
        exp_q.push_back(model(6'h0A, 1'b1, 3'd1));
        step(23);
        e = exp_q.pop_front(); vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL simul_arrive: got %h want %h", obs(), e); end
        serve = 6'h02;
        exp_q.push_back(model(6'h08, 1'b1, 3'd3));
        step(1);
        e = exp_q.pop_front(); vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL simul_handoff: got %h want %h", obs(), e); end
        serve = '0;
        exp_q.push_back(model(6'h08, 1'b1, 3'd3));
        step(5);
        e = exp_q.pop_front(); vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL simul_no_relatch: got %h want %h", obs(), e); end
        serve = 6'h08;
        exp_q.push_back(model(6'h00, 1'b0, 3'd0));
        step(1);
        e = exp_q.pop_front(); vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL simul_all_clear: got %h want %h", obs(), e); end
        serve = '0;
        raw_request = '0;
        step(25);
    endtask

    task automatic test_first_hold();
        logic [13:0] e;
        raw_request = 6'h20;
        step(5);
        raw_request = 6'h21;
        exp_q.push_back(model(6'h20, 1'b1, 3'd5));
        step(18);
        e = exp_q.pop_front(); vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL hold_first5: got %h want %h", obs(), e); end
        exp_q.push_back(model(6'h21, 1'b1, 3'd5));
        step(5);
        e = exp_q.pop_front(); vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL hold_lower_arrives: got %h want %h", obs(), e); end
        serve = 6'h20;
        exp_q.push_back(model(6'h01, 1'b1, 3'd0));
        step(1);
        e = exp_q.pop_front(); vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL hold_recapture: got %h want %h", obs(), e); end
        serve = 6'h01;
        exp_q.push_back(model(6'h00, 1'b0, 3'd0));
        step(1);
        e = exp_q.pop_front(); vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL hold_empty: got %h want %h", obs(), e); end
        serve = '0;
        raw_request = '0;
        step(25);
    endtask

    task automatic test_discard();
        logic [13:0] e;
        serve = 6'h01;
        raw_request = 6'h01;
        exp_q.push_back(model(6'h00, 1'b0, 3'd0));
        step(23);
        e = exp_q.pop_front(); vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL discard_rise_served: got %h want %h", obs(), e); end
        step(5);
        serve = '0;
        exp_q.push_back(model(6'h00, 1'b0, 3'd0));
        step(10);
        e = exp_q.pop_front(); vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL discard_held: got %h want %h", obs(), e); end
        raw_request = '0;
        step(25);
        raw_request = 6'h01;
        exp_q.push_back(model(6'h00, 1'b0, 3'd0));
        step(22);
        e = exp_q.pop_front(); vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL requal_edge22: got %h want %h", obs(), e); end
        exp_q.push_back(model(6'h01, 1'b1, 3'd0));
        step(1);
        e = exp_q.pop_front(); vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL requal_edge23: got %h want %h", obs(), e); end
        serve = 6'h01;
        step(1);
        serve = '0;
        raw_request = '0;
        step(25);
    endtask

    task automatic test_reset_mid();
        logic [13:0] e;
        raw_request = 6'h3F;
        exp_q.push_back(model(6'h3F, 1'b1, 3'd0));
        step(23);
        e = exp_q.pop_front(); vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL rst_all_pending: got %h want %h", obs(), e); end
        #2;
        rst_n = 1'b0;
        exp_q.push_back(model(6'h00, 1'b0, 3'd0));
        #1;
        e = exp_q.pop_front(); vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL rst_async: got %h want %h", obs(), e); end
        step(3);
        rst_n = 1'b1;
        exp_q.push_back(model(6'h00, 1'b0, 3'd0));
        step(22);
        e = exp_q.pop_front(); vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL rst_requal_edge22: got %h want %h", obs(), e); end
        exp_q.push_back(model(6'h3F, 1'b1, 3'd0));
        step(1);
        e = exp_q.pop_front(); vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL rst_requal_edge23: got %h want %h", obs(), e); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_qualify();
        test_glitch();
        test_simultaneous();
        test_first_hold();
        test_discard();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
